rv_int_exec_unit: RTL and testbench

Parametrised multi-cycle integer execute unit for the RV32I register-register (OP, 0110011) and register-immediate (OP-IMM, 0010011) classes. It integrates instruction decode, a 2-read/1-write register file and the ALU behind a valid/ready instruction handshake, and reports completion with a done pulse. Compared with the earlier split decoder/regfile/ALU, it adds:
- sign-extended immediates
- correct SRA/SRL and SUB selection
- x0 hard-wiring
- illegal-instruction flagging
- width/depth parametrisation

---
 rtl/rv_int_exec_unit.sv | 207 ++++++++++++++++++++
 tb/tb_rv_int_exec_unit.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/rv_int_exec_unit.sv
// Multi-cycle RV32I OP/OP-IMM execute unit: decode, 2R/1W register file and ALU
// behind a valid/ready handshake; four-state FSM with a done/illegal pulse.
module rv_int_exec_unit #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    localparam int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    output logic            instr_ready,
    input  logic [31:0]     instr,
    output logic            done,
    output logic            illegal,
    output logic [4:0]      rd_addr_o,
    output logic [XLEN-1:0] result_o,
    input  logic [4:0]      dbg_addr,
    output logic [XLEN-1:0] dbg_data
);
    localparam int RIW = $clog2(NREGS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DEC  = 2'd1;
    localparam logic [1:0] S_EXE  = 2'd2;
    localparam logic [1:0] S_WB   = 2'd3;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    logic [1:0]      state_q, state_d;
    logic [31:0]     instr_q, instr_d;
    logic [XLEN-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic            ill_q, ill_d;
    logic [XLEN-1:0] alu_res_q, alu_res_d;
    logic            done_q, done_d, illegal_q, illegal_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [XLEN-1:0] regs_q [NREGS];
    logic [XLEN-1:0] regs_d [NREGS];

    function automatic logic in_range(input logic [4:0] a);
        return (NREGS == 32) || (32'(a) < NREGS);
    endfunction

    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] a);
        if (a == 5'd0 || !in_range(a)) return '0;
        return regs_q[a[RIW-1:0]];
    endfunction

    logic [6:0]      opcode, f7;
    logic [2:0]      f3;
    logic [4:0]      rs1, rs2, rd;
    logic [11:0]     imm12, imm_chk;
    logic [XLEN-1:0] imm_sx;
    logic            is_op, is_imm, shift_upper;
    logic [3:0]      alu_sel;
    logic            dec_ill;

    assign opcode = instr_q[6:0];
    assign rd     = instr_q[11:7];
    assign f3     = instr_q[14:12];
    assign rs1    = instr_q[19:15];
    assign rs2    = instr_q[24:20];
    assign f7     = instr_q[31:25];
    assign imm12  = instr_q[31:20];
    assign imm_sx = {{(XLEN-12){imm12[11]}}, imm12};
    assign is_op  = (opcode == 7'b0110011);
    assign is_imm = (opcode == 7'b0010011);
    // Bit 30 selects SRAI, so it is excluded from the shamt-overflow check.
    assign imm_chk     = imm12 & ~12'h400;
    assign shift_upper = ((imm_chk >> SHW) != 12'd0);

    always_comb begin
        alu_sel = ALU_ADD;
        unique case (f3)
            3'b000: alu_sel = (is_op && f7[5]) ? ALU_SUB : ALU_ADD;
            3'b001: alu_sel = ALU_SLL;
            3'b010: alu_sel = ALU_SLT;
            3'b011: alu_sel = ALU_SLTU;
            3'b100: alu_sel = ALU_XOR;
            3'b101: alu_sel = f7[5] ? ALU_SRA : ALU_SRL;
            3'b110: alu_sel = ALU_OR;
            3'b111: alu_sel = ALU_AND;
        endcase
        dec_ill = 1'b0;
        if (!is_op && !is_imm) dec_ill = 1'b1;
        if (is_op && f7 != 7'b0000000 && f7 != 7'b0100000) dec_ill = 1'b1;
        if (is_op && f7 == 7'b0100000 && f3 != 3'b000 && f3 != 3'b101)
            dec_ill = 1'b1;
        if (is_imm && (f3 == 3'b001 || f3 == 3'b101) && shift_upper)
            dec_ill = 1'b1;
        if (!in_range(rs1) || !in_range(rd) || (is_op && !in_range(rs2)))
            dec_ill = 1'b1;
    end

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] alu_out;
    assign shamt = op_b_q[SHW-1:0];

    always_comb begin
        alu_out = '0;
        unique case (alu_op_q)
            ALU_ADD:  alu_out = op_a_q + op_b_q;
            ALU_SUB:  alu_out = op_a_q - op_b_q;
            ALU_SLL:  alu_out = op_a_q << shamt;
            ALU_SLT:  alu_out[0] = $signed(op_a_q) < $signed(op_b_q);
            ALU_SLTU: alu_out[0] = op_a_q < op_b_q;
            ALU_XOR:  alu_out = op_a_q ^ op_b_q;
            ALU_SRL:  alu_out = op_a_q >> shamt;
            ALU_SRA:  alu_out = $signed(op_a_q) >>> shamt;
            ALU_OR:   alu_out = op_a_q | op_b_q;
            ALU_AND:  alu_out = op_a_q & op_b_q;
            default:  alu_out = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        instr_d   = instr_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        alu_op_d  = alu_op_q;
        ill_d     = ill_q;
        alu_res_d = alu_res_q;
        rd_addr_d = rd_addr_q;
        result_d  = result_q;
        regs_d    = regs_q;
        done_d    = 1'b0;
        illegal_d = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (instr_valid) begin
                    instr_d = instr;
                    state_d = S_DEC;
                end
            end
            S_DEC: begin
                op_a_d   = rf_read(rs1);
                op_b_d   = is_op ? rf_read(rs2) : imm_sx;
                alu_op_d = alu_sel;
                ill_d    = dec_ill;
                state_d  = S_EXE;
            end
            S_EXE: begin
                alu_res_d = alu_out;
                state_d   = S_WB;
            end
            S_WB: begin
                if (!ill_q && rd != 5'd0 && in_range(rd))
                    regs_d[rd[RIW-1:0]] = alu_res_q;
                result_d  = ill_q ? '0 : alu_res_q;
                rd_addr_d = rd;
                done_d    = 1'b1;
                illegal_d = ill_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            instr_q   <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            alu_op_q  <= ALU_ADD;
            ill_q     <= 1'b0;
            alu_res_q <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            rd_addr_q <= '0;
            result_q  <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            alu_op_q  <= alu_op_d;
            ill_q     <= ill_d;
            alu_res_q <= alu_res_d;
            done_q    <= done_d;
            illegal_q <= illegal_d;
            rd_addr_q <= rd_addr_d;
            result_q  <= result_d;
            regs_q    <= regs_d;
        end
    end

    assign instr_ready = (state_q == S_IDLE);
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign rd_addr_o   = rd_addr_q;
    assign result_o    = result_q;
    assign dbg_data    = rf_read(dbg_addr);

endmodule

// File: tb/tb_rv_int_exec_unit.sv
// Bench for rv_int_exec_unit: vector table issued back-to-back, scoreboard
// checked on each done pulse, then register-file and mid-op reset checks.
module tb_rv_int_exec_unit;
    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        done;
    logic        illegal;
    logic [4:0]  rd_addr_o;
    logic [31:0] result_o;
    logic [4:0]  dbg_addr;
    logic [31:0] dbg_data;

    rv_int_exec_unit #(.XLEN(32), .NREGS(32)) dut (
        .clk(clk), .rst(rst),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .done(done), .illegal(illegal),
        .rd_addr_o(rd_addr_o), .result_o(result_o),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res;
        logic        ill;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        ill;
        logic [4:0]  rd;
        time         t_acc;
    } exp_t;

    int checks = 0;
    int fails  = 0;
    exp_t sb [$];
    exp_t got;
    vec_t vecs [26];
    logic [31:0] rf_exp [32];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] it(input logic [11:0] imm,
        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
        return {imm, rs1, f3, rd, 7'b0010011};
    endfunction

    function automatic logic [31:0] rt(input logic [6:0] f7,
        input logic [4:0] rs2, input logic [4:0] rs1,
        input logic [2:0] f3, input logic [4:0] rd);
        return {f7, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    always @(negedge clk) begin
        if (rst && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", {63'd0, done}, 64'd0);
            end else begin
                got = sb.pop_front();
                chk("result_o", {32'd0, result_o}, {32'd0, got.res});
                chk("illegal", {63'd0, illegal}, {63'd0, got.ill});
                chk("rd_addr_o", {59'd0, rd_addr_o}, {59'd0, got.rd});
                chk("latency", $time - got.t_acc, 64'd35);
            end
        end
    end

    task automatic issue(input logic [31:0] ins, input logic [31:0] res,
                         input logic ill);
        int n = 0;
        @(negedge clk);
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            chk("ready_timeout", {63'd0, instr_ready}, 64'd1);
            return;
        end
        instr_valid = 1'b1;
        instr       = ins;
        @(posedge clk);
        sb.push_back('{res: res, ill: ill, rd: ins[11:7], t_acc: $time});
        if (!ill && ins[11:7] != 5'd0) rf_exp[ins[11:7]] = res;
        #1;
        instr_valid = 1'b0;
        instr       = $urandom();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int seen;
        rst = 1'b0;
        instr_valid = 1'b0;
        instr = '0;
        dbg_addr = '0;
        for (int i = 0; i < 32; i++) rf_exp[i] = '0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_ready", {63'd0, instr_ready}, 64'd1);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_illegal", {63'd0, illegal}, 64'd0);
        chk("rst_result", {32'd0, result_o}, 64'd0);
        chk("rst_rd_addr", {59'd0, rd_addr_o}, 64'd0);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1 chk("rst_dbg", {32'd0, dbg_data}, 64'd0);
        end

        vecs[0]  = '{it(12'hFFB, 5'd0, 3'd0, 5'd1), 32'hFFFFFFFB, 1'b0};
        vecs[1]  = '{it(12'hFFF, 5'd1, 3'd3, 5'd2), 32'h00000001, 1'b0};
        vecs[2]  = '{it(12'h000, 5'd1, 3'd2, 5'd3), 32'h00000001, 1'b0};
        vecs[3]  = '{it(12'h401, 5'd1, 3'd5, 5'd4), 32'hFFFFFFFD, 1'b0};
        vecs[4]  = '{it(12'd28, 5'd1, 3'd5, 5'd5), 32'h0000000F, 1'b0};
        vecs[5]  = '{rt(7'h20, 5'd4, 5'd5, 3'd0, 5'd6), 32'h00000012, 1'b0};
        vecs[6]  = '{it(12'd7, 5'd0, 3'd0, 5'd0), 32'h00000007, 1'b0};
        vecs[7]  = '{rt(7'h00, 5'd5, 5'd1, 3'd4, 5'd8), 32'hFFFFFFF4, 1'b0};
        vecs[8]  = '{rt(7'h00, 5'd5, 5'd4, 3'd6, 5'd9), 32'hFFFFFFFF, 1'b0};
        vecs[9]  = '{rt(7'h00, 5'd4, 5'd1, 3'd7, 5'd10), 32'hFFFFFFF9, 1'b0};
        vecs[10] = '{rt(7'h00, 5'd2, 5'd5, 3'd1, 5'd11), 32'h0000001E, 1'b0};
        vecs[11] = '{rt(7'h00, 5'd1, 5'd5, 3'd2, 5'd12), 32'h00000000, 1'b0};
        vecs[12] = '{rt(7'h00, 5'd1, 5'd5, 3'd3, 5'd13), 32'h00000001, 1'b0};
        vecs[13] = '{rt(7'h20, 5'd5, 5'd1, 3'd5, 5'd14), 32'hFFFFFFFF, 1'b0};
        vecs[14] = '{rt(7'h00, 5'd2, 5'd1, 3'd5, 5'd15), 32'h7FFFFFFD, 1'b0};
        vecs[15] = '{it(12'h0F0, 5'd1, 3'd7, 5'd16), 32'h000000F0, 1'b0};
        vecs[16] = '{it(12'h800, 5'd0, 3'd6, 5'd17), 32'hFFFFF800, 1'b0};
        vecs[17] = '{it(12'hFFF, 5'd5, 3'd4, 5'd18), 32'hFFFFFFF0, 1'b0};
        vecs[18] = '{it(12'd4, 5'd5, 3'd1, 5'd19), 32'h000000F0, 1'b0};
        vecs[19] = '{{12'h005, 5'd1, 3'd0, 5'd20, 7'b0000011}, 32'h0, 1'b1};
        vecs[20] = '{rt(7'h20, 5'd2, 5'd1, 3'd7, 5'd21), 32'h0, 1'b1};
        vecs[21] = '{rt(7'h01, 5'd2, 5'd1, 3'd0, 5'd22), 32'h0, 1'b1};
        vecs[22] = '{it(12'h801, 5'd5, 3'd1, 5'd23), 32'h0, 1'b1};
        vecs[23] = '{it(12'h020, 5'd5, 3'd5, 5'd24), 32'h0, 1'b1};
        vecs[24] = '{rt(7'h00, 5'd1, 5'd5, 3'd0, 5'd25), 32'h0000000A, 1'b0};
        vecs[25] = '{rt(7'h20, 5'd25, 5'd25, 3'd0, 5'd26), 32'h0, 1'b0};

        for (int i = 0; i < 26; i++)
            issue(vecs[i].instr, vecs[i].res, vecs[i].ill);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("drain", 64'(sb.size()), 64'd0);
        @(negedge clk);
        for (int a = 0; a < 32; a++) begin
            dbg_addr = 5'(a);
            #1 chk("rf_final", {32'd0, dbg_data}, {32'd0, rf_exp[a]});
        end

        @(negedge clk);
        instr_valid = 1'b1;
        instr = it(12'd9, 5'd0, 3'd0, 5'd7);
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (done) seen++;
        end
        chk("midop_no_done", 64'(seen), 64'd0);
        chk("midop_ready", {63'd0, instr_ready}, 64'd1);
        dbg_addr = 5'd7;
        #1 chk("midop_x7", {32'd0, dbg_data}, 64'd0);
        dbg_addr = 5'd1;
        #1 chk("midop_x1_cleared", {32'd0, dbg_data}, 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
